// File: rtl/instr_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : instr_loader_pkg
// Brief    : Shared types and constants for the instruction memory loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_loader_pkg;

  localparam int unsigned C_MEM_WORDS_DFLT = 1024;
  localparam logic [31:0] C_NOP            = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RUN   = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/loader_checksum.sv
//------------------------------------------------------------------------------
// Module   : loader_checksum
// Brief    : 32-bit wrapping accumulator with clear, add and compare.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module loader_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [31:0] i_data,
  input  logic [31:0] i_cmp,
  output logic        o_match
);

  logic [31:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match = (r_sum == i_cmp);

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module   : instr_mem_loader_ctrl
// Brief    : Boot loader owning the instruction memory port; holds the core in
//            reset while streaming an image in. Optional trailer checksum
//            verification is enabled with LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_mem_loader_ctrl
  import instr_loader_pkg::*;
#(
  parameter int MEM_WORDS = C_MEM_WORDS_DFLT,
  parameter int LEN_W     = $clog2(MEM_WORDS) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] load_len_i,
  input  logic             load_valid_i,
  input  logic [31:0]      load_data_i,
  output logic             load_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic [31:0]      fetch_addr_i,
  output logic [31:0]      fetch_data_o,
  output logic             core_rst_o,
  output logic             done_o,
  output logic             err_o
);

  loader_state_t    r_state, w_next;
  logic [LEN_W-1:0] r_len, r_idx;
  logic             r_err, r_done;
  logic             w_start_evt, w_len_bad, w_len_zero, w_start_load;
  logic             w_ready, w_accept, w_last, w_enter_run, w_set_err;

  assign w_start_evt  = start_i && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_len_bad    = load_len_i > LEN_W'(MEM_WORDS);
  assign w_len_zero   = (load_len_i == '0);
  assign w_start_load = w_start_evt && !w_len_bad && !w_len_zero;
  assign w_accept     = load_valid_i && w_ready;
  assign w_last       = (r_idx == (r_len - LEN_W'(1)));
  // A zero-length restart from RUN re-enters RUN and pulses done again.
  assign w_enter_run  = (w_next == ST_RUN) && ((r_state != ST_RUN) || w_start_evt);

`ifdef LOADER_CHECKSUM_EN
  logic w_cks_match;

  loader_checksum u_checksum (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_clr   (w_start_evt),
    .i_add   (w_accept && (r_state == ST_LOAD)),
    .i_data  (load_data_i),
    .i_cmp   (load_data_i),
    .o_match (w_cks_match)
  );

  assign w_set_err = (w_start_evt && w_len_bad) ||
                     ((r_state == ST_CHECK) && load_valid_i && !w_cks_match);
`else
  assign w_set_err = w_start_evt && w_len_bad;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (start_i) begin
          if (w_len_bad)       w_next = ST_IDLE;
          else if (w_len_zero) w_next = ST_RUN;
          else                 w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept && w_last) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = ST_CHECK;
`else
          w_next = ST_RUN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (load_valid_i) w_next = w_cks_match ? ST_RUN : ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready      = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    load_ready_o = w_ready;
    mem_we_o     = (r_state == ST_LOAD) && w_accept;
    mem_wdata_o  = load_data_i;
    mem_addr_o   = 32'({r_idx, 2'b00});
    fetch_data_o = C_NOP;
    core_rst_o   = 1'b1;
    if (r_state == ST_RUN) begin
      mem_addr_o   = fetch_addr_i;
      fetch_data_o = mem_rdata_i;
      core_rst_o   = 1'b0;
    end
    done_o = r_done;
    err_o  = r_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_enter_run;
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (w_start_evt) begin
        r_err <= 1'b0;
      end
      if (w_start_load) begin
        r_len <= load_len_i;
        r_idx <= '0;
      end else if (mem_we_o) begin
        r_idx <= r_idx + LEN_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_mem_loader_ctrl
// Brief    : Directed self-checking bench for instr_mem_loader_ctrl; covers the
//            trailer checksum path when LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_loader_ctrl;

  localparam int MEM_WORDS = 1024;
  localparam int LEN_W     = 11;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [LEN_W-1:0] load_len_i;
  logic             load_valid_i;
  logic [31:0]      load_data_i;
  logic             load_ready_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i;
  logic [31:0]      fetch_addr_i;
  logic [31:0]      fetch_data_o;
  logic             core_rst_o;
  logic             done_o;
  logic             err_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:MEM_WORDS-1];

  instr_mem_loader_ctrl #(.MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .load_len_i   (load_len_i),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .fetch_addr_i (fetch_addr_i),
    .fetch_data_o (fetch_data_o),
    .core_rst_o   (core_rst_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_o[11:2]] <= mem_wdata_o;
  end
  assign mem_rdata_i = mem[mem_addr_o[11:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_load(input int len);
    start_i    = 1'b1;
    load_len_i = LEN_W'(len);
    #1;
    chk("start_no_we", 32'(mem_we_o), 32'd0);
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_word(input int i, input logic [31:0] w);
    load_valid_i = 1'b1;
    load_data_i  = w;
    #1;
    chk("word_ready", 32'(load_ready_o), 32'd1);
    chk("word_we",    32'(mem_we_o),     32'd1);
    chk("word_addr",  mem_addr_o,        32'(i * 4));
    chk("word_wdata", mem_wdata_o,       w);
    tick();
    load_valid_i = 1'b0;
  endtask

  task automatic gap();
    #1;
    chk("gap_no_we", 32'(mem_we_o),     32'd0);
    chk("gap_ready", 32'(load_ready_o), 32'd1);
    tick();
  endtask

  // Trailer phase; a no-op in the plain build where LOAD goes straight to RUN.
  task automatic send_trailer(input logic [31:0] sum);
`ifdef LOADER_CHECKSUM_EN
    #1;
    chk("chk_ready",   32'(load_ready_o), 32'd1);
    chk("chk_corerst", 32'(core_rst_o),   32'd1);
    load_valid_i = 1'b1;
    load_data_i  = sum;
    #1;
    chk("chk_no_we", 32'(mem_we_o), 32'd0);
    tick();
    load_valid_i = 1'b0;
`else
    load_data_i = sum;
`endif
  endtask

  task automatic expect_run_entry(input string tag);
    #1;
    chk({tag, "_corerst"}, 32'(core_rst_o),   32'd0);
    chk({tag, "_done"},    32'(done_o),       32'd1);
    chk({tag, "_ready"},   32'(load_ready_o), 32'd0);
    tick();
    chk({tag, "_done_off"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    load_len_i   = '0;
    load_valid_i = 1'b0;
    load_data_i  = '0;
    fetch_addr_i = 32'h40;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_corerst", 32'(core_rst_o),   32'd1);
    chk("rst_ready",   32'(load_ready_o), 32'd0);
    chk("rst_we",      32'(mem_we_o),     32'd0);
    chk("rst_done",    32'(done_o),       32'd0);
    chk("rst_err",     32'(err_o),        32'd0);
    chk("rst_addr",    mem_addr_o,        32'd0);
    chk("rst_fetch",   fetch_data_o,      32'h13);
    fetch_addr_i = 32'h8;
    #1;
    chk("rst_fetch2", fetch_data_o, 32'h13);

    // Back-to-back load of three words
    start_load(3);
    send_word(0, 32'hAAAA_0001);
    send_word(1, 32'hBBBB_0002);
    send_word(2, 32'hCCCC_0003);
    send_trailer(32'hAAAA_0001 + 32'hBBBB_0002 + 32'hCCCC_0003);
    expect_run_entry("b2b");
    fetch_addr_i = 32'h4;
    #1;
    chk("run_fetch_b",  fetch_data_o, 32'hBBBB_0002);
    chk("run_addr_mux", mem_addr_o,   32'h4);

    // Reload from RUN with two idle cycles between words
    start_load(3);
    chk("reload_corerst", 32'(core_rst_o), 32'd1);
    chk("reload_nop",     fetch_data_o,    32'h13);
    send_word(0, 32'h1111_0000);
    gap();
    gap();
    send_word(1, 32'h2222_0000);
    gap();
    gap();
    send_word(2, 32'h3333_0000);
    send_trailer(32'h6666_0000);
    expect_run_entry("gap");
    fetch_addr_i = 32'h8;
    #1;
    chk("gap_fetch_c", fetch_data_o, 32'h3333_0000);

    // Oversized length, then a zero-length start that clears the error
    start_load(MEM_WORDS + 1);
    #1;
    chk("big_err",     32'(err_o),        32'd1);
    chk("big_corerst", 32'(core_rst_o),   32'd1);
    chk("big_ready",   32'(load_ready_o), 32'd0);
    chk("big_done",    32'(done_o),       32'd0);
    start_load(0);
    chk("zero_err", 32'(err_o), 32'd0);
    expect_run_entry("zero");

    // Reset in the middle of a five-word load
    start_load(5);
    send_word(0, 32'h5555_0000);
    send_word(1, 32'h5555_0001);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("midrst_corerst", 32'(core_rst_o),   32'd1);
    chk("midrst_ready",   32'(load_ready_o), 32'd0);
    chk("midrst_kept",    mem[1],            32'h5555_0001);
    start_load(1);
    send_word(0, 32'h7777_0007);
    send_trailer(32'h7777_0007);
    expect_run_entry("one");
    fetch_addr_i = 32'h0;
    #1;
    chk("one_fetch", fetch_data_o, 32'h7777_0007);

`ifdef LOADER_CHECKSUM_EN
    // Bad trailer: back to IDLE with error, trailer never written
    mem[3] = 32'hDEAD_BEEF;
    start_load(3);
    send_word(0, 32'd1);
    send_word(1, 32'd2);
    send_word(2, 32'd3);
    send_trailer(32'd7);
    #1;
    chk("badsum_err",     32'(err_o),        32'd1);
    chk("badsum_corerst", 32'(core_rst_o),   32'd1);
    chk("badsum_ready",   32'(load_ready_o), 32'd0);
    chk("badsum_done",    32'(done_o),       32'd0);
    chk("badsum_mem3",    mem[3],            32'hDEAD_BEEF);
    start_load(3);
    send_word(0, 32'd1);
    send_word(1, 32'd2);
    send_word(2, 32'd3);
    send_trailer(32'd6);
    chk("goodsum_err", 32'(err_o), 32'd0);
    expect_run_entry("goodsum");
    chk("goodsum_mem3", mem[3], 32'hDEAD_BEEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_mem_loader_ctrl.md
# instr_mem_loader_ctrl

Boot-time controller that owns the instruction memory's single address/write port. It holds the core in reset while a program image is streamed in over a valid/ready interface and written word by word. It then releases the core and hands the memory port to the fetch path. In RUN it is a transparent mux; outside RUN the fetch path sees NOPs.

## Interface
- MEM_WORDS, 1024, instruction memory depth in 32-bit words
- LEN_W, $clog2(MEM_WORDS)+1, width of the length input
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a load; sampled in IDLE or RUN
- load_len_i  in  LEN_W  number of program words; sampled with start_i
- load_valid_i  in  1  loader word valid
- load_data_i  in  32  loader word
- load_ready_o  out  1  controller accepts a word
- mem_we_o  out  1  write strobe to instruction memory
- mem_addr_o  out  32  byte address to instruction memory
- mem_wdata_o  out  32  write data to instruction memory
- mem_rdata_i  in  32  combinational read data from instruction memory
- fetch_addr_i  in  32  core fetch byte address
- fetch_data_o  out  32  instruction returned to core
- core_rst_o  out  1  core reset; high whenever state != RUN
- done_o  out  1  one-cycle pulse on the first RUN cycle
- err_o  out  1  sticky load error; cleared by an accepted start_i

## Operation
- States:
  - IDLE (reset state)
  - LOAD
  - CHECK (only with the macro)
  - RUN
- IDLE or RUN with start_i=1:
  - load_len_i > MEM_WORDS → err_o=1, go to or stay in IDLE.
  - load_len_i = 0 → RUN.
  - Otherwise latch the length, clear the word index, clear err_o, go to LOAD.
- start_i while in LOAD or CHECK is ignored.
- LOAD:
  - load_ready_o=1.
  - Accept = load_valid_i & load_ready_o.
  - On accept: mem_we_o=1, mem_addr_o={idx,2'b00}, mem_wdata_o=load_data_i, idx++.
  - After the accept of word len-1 → RUN (or CHECK with the macro).
- RUN: mem_addr_o=fetch_addr_i; fetch_data_o=mem_rdata_i; mem_we_o=0.
- Outside RUN: fetch_data_o=32'h0000_0013 (NOP). Outside a LOAD accept: mem_addr_o={idx,2'b00}.
- Arithmetic: idx is LEN_W bits wide and never exceeds MEM_WORDS; addresses are word-aligned. Checksum is a 32-bit wrapping sum.

## Timing
- Reset values:
  - state=IDLE
  - core_rst_o=1
  - load_ready_o=0
  - mem_we_o=0
  - done_o=0
  - err_o=0
  - idx=0
  - fetch_data_o=NOP
- Handshake and write:
  - load_ready_o is combinational from state.
  - mem_we_o/addr/wdata are combinational from the accept, so the memory writes on the same clock edge.
  - Zero-latency acceptance; one word per cycle maximum.
  - load_valid_i low: no write, idx holds.
- Last word accepted at edge N → state=RUN after edge N. In that cycle core_rst_o=0 and done_o=1; done_o=0 from the next cycle.
- rst_i mid-LOAD or mid-CHECK → IDLE next edge, core_rst_o=1. Already-written memory words are left as written.
- start_i in RUN → core_rst_o=1 from the next cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last data word, CHECK keeps load_ready_o=1 for exactly one trailer word.
  - The trailer word is not written to memory.
  - Trailer == wrapping sum of all data words → RUN with done_o.
  - Otherwise → IDLE with err_o=1 and core_rst_o=1.
  - With len=0 the zero-length rule still applies: go to RUN directly, no trailer.
- LOADER_CHECKSUM_EN undefined: there is no CHECK state and no accumulator, and the controller goes from LOAD straight to RUN.

## Structure
- Package instr_loader_pkg holds:
  - The state enum typedef (loader_state_t).
  - The MEM_WORDS default.
  - The NOP constant (32'h0000_0013).
- One sub-module, loader_checksum: a 32-bit accumulator with clear/add/compare. It is instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- Reset with start_i=0 → all outputs at reset values; fetch_data_o=32'h13 for any fetch_addr_i.
- start_i, len=3, words A,B,C back-to-back → writes to addresses 0, 4, 8. Next cycle: core_rst_o=0 and done_o=1. fetch_addr_i=4 then returns B.
- Same load with load_valid_i low for 2 cycles between words → no mem_we_o during the gaps. Addresses are still 0, 4, 8, and RUN follows the third accept.
- len=0 → RUN one cycle after start_i with no writes. len=MEM_WORDS+1 → err_o=1, state IDLE, core_rst_o=1. A following valid start clears err_o.
- rst_i asserted after 2 of 5 words → IDLE, core_rst_o=1, load_ready_o=0. A new start with len=1 writes address 0.
- LOADER_CHECKSUM_EN with words 1, 2, 3:
  - Trailer 6 → RUN.
  - Trailer 7 → IDLE, err_o=1, and the trailer is never written.
